// File: rtl/lgez_extremum_tracker_pkg.sv
// lgez_extremum_tracker_pkg: lgez comparator codes and tracker states.
// Shared by CmpLgezNBit and lgez_extremum_tracker.
package lgez_extremum_tracker_pkg;

    localparam logic [1:0] CMP_EQ_Z    = 2'b00;
    localparam logic [1:0] CMP_LESS    = 2'b01;
    localparam logic [1:0] CMP_GREATER = 2'b10;
    localparam logic [1:0] CMP_EQ_NZ   = 2'b11;

    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_TRACK = 2'b01,
        S_FULL  = 2'b10
    } state_e;

endpackage

// File: rtl/lgez_extremum_tracker_cmp.sv
// CmpLgezNBit: unsigned compare of i_a against i_b, returning the lgez code
// (00 both zero, 01 less, 10 greater, 11 equal non-zero).
module CmpLgezNBit
    import lgez_extremum_tracker_pkg::*;
#(
    parameter int p_WIDTH = 8
) (
    input  logic [p_WIDTH-1:0] i_a,
    input  logic [p_WIDTH-1:0] i_b,
    output logic [1:0]         o_code
);

    always_comb begin
        o_code = CMP_EQ_Z;
        if (i_a > i_b) begin
            o_code = CMP_GREATER;
        end else if (i_a < i_b) begin
            o_code = CMP_LESS;
        end else if (i_a != '0) begin
            o_code = CMP_EQ_NZ;
        end
    end

endmodule

// File: rtl/lgez_extremum_tracker.sv
// lgez_extremum_tracker: two-stage streaming min/max/count tracker.
// Define LGEZ_TRACK_SAT_EN to saturate the count and stall input at MAX_CNT.
module lgez_extremum_tracker
    import lgez_extremum_tracker_pkg::*;
#(
    parameter int p_WIDTH     = 8,
    parameter int p_CNT_WIDTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_clear,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [p_WIDTH-1:0]     i_data,
    output logic [p_WIDTH-1:0]     o_max,
    output logic [p_WIDTH-1:0]     o_min,
    output logic [p_CNT_WIDTH-1:0] o_count,
    output logic                   o_stat_valid,
    output logic [1:0]             o_code
);

    localparam logic [p_CNT_WIDTH-1:0] CNT_ONE = 1;
`ifdef LGEZ_TRACK_SAT_EN
    localparam logic [p_CNT_WIDTH-1:0] MAX_CNT = '1;
    localparam logic [p_CNT_WIDTH-1:0] MAX_M1  = MAX_CNT - CNT_ONE;
`endif

    logic [p_WIDTH-1:0]     r_data_q, r_data_d;
    logic                   r_vld_q, r_vld_d;
    logic [p_WIDTH-1:0]     max_q, max_d;
    logic [p_WIDTH-1:0]     min_q, min_d;
    logic [p_CNT_WIDTH-1:0] count_q, count_d;
    logic [1:0]             code_q, code_d;
    state_e                 state_q, state_d;

    logic [1:0] max_code;
    logic [1:0] min_code;
    logic       accept;

    CmpLgezNBit #(.p_WIDTH(p_WIDTH)) u_cmp_max (
        .i_a    (r_data_q),
        .i_b    (max_q),
        .o_code (max_code)
    );

    CmpLgezNBit #(.p_WIDTH(p_WIDTH)) u_cmp_min (
        .i_a    (r_data_q),
        .i_b    (min_q),
        .o_code (min_code)
    );

    // Stall one cycle early when a sample already in flight will fill the count.
    always_comb begin
        o_ready = 1'b1;
        if (i_rst || i_clear) begin
            o_ready = 1'b0;
        end
`ifdef LGEZ_TRACK_SAT_EN
        else if (state_q == S_FULL || count_q == MAX_CNT ||
                 (count_q == MAX_M1 && r_vld_q)) begin
            o_ready = 1'b0;
        end
`endif
    end

    assign accept = i_valid && o_ready;

    always_comb begin
        r_data_d = r_data_q;
        r_vld_d  = accept;
        max_d    = max_q;
        min_d    = min_q;
        count_d  = count_q;
        code_d   = code_q;
        state_d  = state_q;

        if (accept) begin
            r_data_d = i_data;
        end

        if (r_vld_q) begin
`ifdef LGEZ_TRACK_SAT_EN
            if (count_q != MAX_CNT) begin
                count_d = count_q + CNT_ONE;
            end
`else
            count_d = count_q + CNT_ONE;
`endif
            unique case (state_q)
                S_EMPTY: begin
                    max_d   = r_data_q;
                    min_d   = r_data_q;
                    code_d  = (r_data_q == '0) ? CMP_EQ_Z : CMP_GREATER;
                    state_d = S_TRACK;
                end
                S_TRACK, S_FULL: begin
                    if (max_code == CMP_GREATER) begin
                        max_d = r_data_q;
                    end
                    if (min_code == CMP_LESS) begin
                        min_d = r_data_q;
                    end
                    code_d = max_code;
                end
                default: state_d = S_EMPTY;
            endcase
`ifdef LGEZ_TRACK_SAT_EN
            if (count_d == MAX_CNT) begin
                state_d = S_FULL;
            end
`endif
        end

        if (i_clear) begin
            r_vld_d = 1'b0;
            max_d   = '0;
            min_d   = '0;
            count_d = '0;
            code_d  = CMP_EQ_Z;
            state_d = S_EMPTY;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data_q <= '0;
            r_vld_q  <= 1'b0;
            max_q    <= '0;
            min_q    <= '0;
            count_q  <= '0;
            code_q   <= CMP_EQ_Z;
            state_q  <= S_EMPTY;
        end else begin
            r_data_q <= r_data_d;
            r_vld_q  <= r_vld_d;
            max_q    <= max_d;
            min_q    <= min_d;
            count_q  <= count_d;
            code_q   <= code_d;
            state_q  <= state_d;
        end
    end

    assign o_max        = max_q;
    assign o_min        = min_q;
    assign o_count      = count_q;
    assign o_code       = code_q;
    assign o_stat_valid = (state_q != S_EMPTY);

endmodule

// File: tb/tb_lgez_extremum_tracker.sv
// Randomized self-checking bench for lgez_extremum_tracker (3-bit data, 3-bit count).
module tb_lgez_extremum_tracker;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_clear = 1'b0;
    logic       i_valid = 1'b0;
    logic       o_ready;
    logic [2:0] i_data = '0;
    logic [2:0] o_max;
    logic [2:0] o_min;
    logic [2:0] o_count;
    logic       o_stat_valid;
    logic [1:0] o_code;

    int checks = 0;
    int errors = 0;

    // reference model state
    int   m_max, m_min, m_cnt, m_code;
    bit   m_has, m_pend;
    int   m_pdata;
    logic rdy_obs;
    bit   rdy_exp;

    lgez_extremum_tracker #(.p_WIDTH(3), .p_CNT_WIDTH(3)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_clear      (i_clear),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_data       (i_data),
        .o_max        (o_max),
        .o_min        (o_min),
        .o_count      (o_count),
        .o_stat_valid (o_stat_valid),
        .o_code       (o_code)
    );

    always #5 i_clk = ~i_clk;

    function automatic bit model_ready(input bit clr, input bit rst);
        if (clr || rst) return 1'b0;
`ifdef LGEZ_TRACK_SAT_EN
        if (m_cnt == 7 || (m_cnt == 6 && m_pend)) return 1'b0;
`endif
        return 1'b1;
    endfunction

    task automatic model_commit(input int v);
        if (!m_has) begin
            m_code = (v == 0) ? 0 : 2;
            m_max  = v;
            m_min  = v;
            m_has  = 1'b1;
        end else begin
            if (v > m_max)       m_code = 2;
            else if (v < m_max)  m_code = 1;
            else if (v == 0)     m_code = 0;
            else                 m_code = 3;
            if (v > m_max) m_max = v;
            if (v < m_min) m_min = v;
        end
`ifdef LGEZ_TRACK_SAT_EN
        if (m_cnt < 7) m_cnt = m_cnt + 1;
`else
        m_cnt = (m_cnt + 1) % 8;
`endif
    endtask

    task automatic model_reset();
        m_max = 0; m_min = 0; m_cnt = 0; m_code = 0;
        m_has = 1'b0; m_pend = 1'b0; m_pdata = 0;
    endtask

    task automatic tick(input bit v, input int d, input bit clr, input bit rst);
        bit acc;
        i_valid = v;
        i_data  = 3'(d);
        i_clear = clr;
        i_rst   = rst;
        #4;
        rdy_obs = o_ready;
        rdy_exp = model_ready(clr, rst);
        acc = v && rdy_exp;
        @(posedge i_clk);
        if (clr || rst) begin
            model_reset();
        end else begin
            if (m_pend) model_commit(m_pdata);
            m_pend  = acc;
            m_pdata = d;
        end
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        tick(1'b1, 5, 1'b0, 1'b1);
        tick(1'b1, 5, 1'b0, 1'b1);
        checks++;
        if (rdy_obs !== 1'b0) begin
            errors++; $display("FAIL reset_ready got %b want 0", rdy_obs);
        end
        checks++;
        if ({o_max, o_min, o_count, o_code, o_stat_valid} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs got max=%0d min=%0d cnt=%0d code=%b sv=%b want all 0",
                     o_max, o_min, o_count, o_code, o_stat_valid);
        end
        tick(1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (rdy_obs !== 1'b1 || o_stat_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got rdy=%b sv=%b want rdy=1 sv=0", rdy_obs, o_stat_valid);
        end
    endtask

    task automatic test_ordered();
        int         dat[5]   = '{5, 2, 7, 7, 0};
        logic [1:0] codes[5] = '{2'b10, 2'b01, 2'b10, 2'b11, 2'b01};
        for (int i = 0; i < 6; i++) begin
            if (i < 5) tick(1'b1, dat[i], 1'b0, 1'b0);
            else       tick(1'b0, 0, 1'b0, 1'b0);
            checks++;
            if (o_count !== 3'(i)) begin
                errors++; $display("FAIL ordered_latency[%0d] count got %0d want %0d", i, o_count, i);
            end
            if (i > 0) begin
                checks++;
                if (o_code !== codes[i-1]) begin
                    errors++; $display("FAIL ordered_code[%0d] got %b want %b", i-1, o_code, codes[i-1]);
                end
            end
        end
        checks++;
        if (o_max !== 3'd7 || o_min !== 3'd0 || o_count !== 3'd5) begin
            errors++;
            $display("FAIL ordered_final got max=%0d min=%0d cnt=%0d want 7 0 5", o_max, o_min, o_count);
        end
    endtask

    task automatic test_zero_only();
        tick(1'b0, 0, 1'b1, 1'b0);
        tick(1'b1, 0, 1'b0, 1'b0);
        tick(1'b1, 0, 1'b0, 1'b0);
        tick(1'b0, 0, 1'b0, 1'b0);
        tick(1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (o_max !== 3'd0 || o_min !== 3'd0 || o_code !== 2'b00 ||
            o_stat_valid !== 1'b1 || o_count !== 3'd2) begin
            errors++;
            $display("FAIL zero_only got max=%0d min=%0d code=%b sv=%b cnt=%0d want 0 0 00 1 2",
                     o_max, o_min, o_code, o_stat_valid, o_count);
        end
    endtask

    task automatic test_back_to_back();
        tick(1'b0, 0, 1'b1, 1'b0);
        tick(1'b1, 4, 1'b0, 1'b0);
        tick(1'b1, 4, 1'b0, 1'b0);
        tick(1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (o_code !== 2'b11 || o_max !== 3'd4 || o_min !== 3'd4) begin
            errors++;
            $display("FAIL back_to_back got code=%b max=%0d min=%0d want 11 4 4", o_code, o_max, o_min);
        end
    endtask

    task automatic test_clear();
        tick(1'b1, 3, 1'b0, 1'b0);
        tick(1'b1, 1, 1'b0, 1'b0);
        tick(1'b1, 6, 1'b0, 1'b0);
        tick(1'b1, 5, 1'b1, 1'b0);
        checks++;
        if (rdy_obs !== 1'b0) begin
            errors++; $display("FAIL clear_ready got %b want 0", rdy_obs);
        end
        checks++;
        if (o_count !== 3'd0 || o_stat_valid !== 1'b0 || o_code !== 2'b00) begin
            errors++;
            $display("FAIL clear_state got cnt=%0d sv=%b code=%b want 0 0 00", o_count, o_stat_valid, o_code);
        end
        tick(1'b0, 0, 1'b0, 1'b0);
        tick(1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (o_count !== 3'd0 || o_stat_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_flush got cnt=%0d sv=%b want 0 0", o_count, o_stat_valid);
        end
    endtask

`ifdef LGEZ_TRACK_SAT_EN
    task automatic test_saturation();
        int n_acc = 0;
        tick(1'b0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, $urandom_range(0, 7), 1'b0, 1'b0);
            checks++;
            if (rdy_obs !== logic'(n_acc < 7)) begin
                errors++; $display("FAIL sat_ready[%0d] got %b want %b", i, rdy_obs, n_acc < 7);
            end
            if (rdy_obs === 1'b1) n_acc++;
        end
        tick(1'b0, 0, 1'b0, 1'b0);
        tick(1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (n_acc != 7 || o_count !== 3'd7) begin
            errors++; $display("FAIL sat_count got acc=%0d cnt=%0d want 7 7", n_acc, o_count);
        end
        checks++;
        if (o_max !== 3'(m_max) || o_min !== 3'(m_min)) begin
            errors++; $display("FAIL sat_extrema got %0d/%0d want %0d/%0d", o_max, o_min, m_max, m_min);
        end
    endtask
`else
    task automatic test_wrap();
        bit rdy_all = 1'b1;
        tick(1'b0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) begin
            tick(1'b1, $urandom_range(1, 6), 1'b0, 1'b0);
            if (rdy_obs !== 1'b1) rdy_all = 1'b0;
        end
        tick(1'b0, 0, 1'b0, 1'b0);
        tick(1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (!rdy_all) begin
            errors++; $display("FAIL wrap_ready got a low o_ready want always 1");
        end
        checks++;
        if (o_count !== 3'd1 || o_stat_valid !== 1'b1) begin
            errors++; $display("FAIL wrap_count got cnt=%0d sv=%b want 1 1", o_count, o_stat_valid);
        end
        checks++;
        if (o_max !== 3'(m_max) || o_min !== 3'(m_min)) begin
            errors++; $display("FAIL wrap_extrema got %0d/%0d want %0d/%0d", o_max, o_min, m_max, m_min);
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            tick(($urandom_range(0, 3) != 0), $urandom_range(0, 7),
                 ($urandom_range(0, 31) == 0), ($urandom_range(0, 99) == 0));
            checks++;
            if (rdy_obs !== rdy_exp) begin
                errors++; $display("FAIL rand_ready[%0d] got %b want %b", i, rdy_obs, rdy_exp);
            end
            checks++;
            if (o_max !== 3'(m_max) || o_min !== 3'(m_min) || o_count !== 3'(m_cnt) ||
                o_code !== 2'(m_code) || o_stat_valid !== m_has) begin
                errors++;
                $display("FAIL rand_out[%0d] got max=%0d min=%0d cnt=%0d code=%b sv=%b want %0d %0d %0d %0d %b",
                         i, o_max, o_min, o_count, o_code, o_stat_valid,
                         m_max, m_min, m_cnt, m_code, m_has);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ordered();
        test_zero_only();
        test_back_to_back();
        test_clear();
`ifdef LGEZ_TRACK_SAT_EN
        test_saturation();
`else
        test_wrap();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
